// File: rtl/keypad_pkg.sv
// Shared types, row-select constants and helper functions for the keypad scanner.
package keypad_pkg;

  typedef logic [3:0]  key_code_t;
  typedef logic [15:0] key_map_t;
  typedef logic [3:0]  row_sel_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } hs_state_e;

  localparam row_sel_t ROW_SEL [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic key_code_t lowest_set(input key_map_t m);
    key_code_t idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (m[i]) idx = key_code_t'(i);
    end
    return idx;
  endfunction

  function automatic logic [4:0] popcount16(input key_map_t m);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, m[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Whole-frame debouncer: stable key map plus lowest newly-pressed key event.
// Build option KEYPAD_GHOST_REJECT_EN discards frames with more than two keys down.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      eval_i,
  input  key_map_t  frame_i,
  output key_map_t  keys_o,
  output logic      any_key_o,
  output logic      event_o,
  output key_code_t event_idx_o
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] MATCH_MAX = CNT_W'(DEBOUNCE_FRAMES);
  localparam logic [CNT_W-1:0] MATCH_ONE = CNT_W'(1);

  key_map_t         prev_q, prev_d;
  key_map_t         keys_q, keys_d;
  key_map_t         keys_old_q, keys_old_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic             any_key_q, any_key_d;
  logic             check_q, check_d;
  logic             accept_s;
  key_map_t         newly_s;

  always_comb begin
`ifdef KEYPAD_GHOST_REJECT_EN
    accept_s = eval_i && (popcount16(frame_i) <= 5'd2);
`else
    accept_s = eval_i;
`endif
    prev_d     = prev_q;
    match_d    = match_q;
    keys_d     = keys_q;
    keys_old_d = keys_old_q;
    check_d    = 1'b0;
    if (accept_s) begin
      if (frame_i == prev_q) begin
        match_d = (match_q == MATCH_MAX) ? match_q : match_q + MATCH_ONE;
      end else begin
        match_d = MATCH_ONE;
      end
      prev_d = frame_i;
      // Load only on reaching the threshold, so a held map is not re-reported.
      if ((match_d == MATCH_MAX) && ((match_q != MATCH_MAX) || (frame_i != prev_q))) begin
        keys_old_d = keys_q;
        keys_d     = frame_i;
        check_d    = 1'b1;
      end else begin
        keys_d = keys_q;
      end
    end else begin
      prev_d = prev_q;
    end
    any_key_d = |keys_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q     <= 16'h0000;
      keys_q     <= 16'h0000;
      keys_old_q <= 16'h0000;
      match_q    <= '0;
      any_key_q  <= 1'b0;
      check_q    <= 1'b0;
    end else begin
      prev_q     <= prev_d;
      keys_q     <= keys_d;
      keys_old_q <= keys_old_d;
      match_q    <= match_d;
      any_key_q  <= any_key_d;
      check_q    <= check_d;
    end
  end

  assign newly_s     = keys_q & ~keys_old_q;
  assign event_o     = check_q && (newly_s != 16'h0000);
  assign event_idx_o = lowest_set(newly_s);
  assign keys_o      = keys_q;
  assign any_key_o   = any_key_q;

endmodule

// File: rtl/keypad_scan.sv
// Scanned 4x4 keypad reader: row drive, column synchroniser, frame capture and valid/ack handshake.
// Build option KEYPAD_GHOST_REJECT_EN (in keypad_debounce) rejects frames with more than two keys.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV        = 1000,
  parameter int unsigned DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_n,
  input  logic        key_ack,
  output logic [3:0]  row_n,
  output logic [15:0] keys,
  output logic        any_key,
  output logic        key_valid,
  output logic [3:0]  key_code,
  output logic        overrun
);

  localparam int unsigned SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
  localparam logic [SCAN_W-1:0] SCAN_ONE  = SCAN_W'(1);

  logic [3:0]        col_meta_q, col_sync_q;
  logic [SCAN_W-1:0] scan_cnt_q, scan_cnt_d;
  logic [1:0]        row_idx_q, row_idx_d;
  row_sel_t          row_n_q, row_n_d;
  key_map_t          frame_q, frame_d;
  logic              frame_done_q, frame_done_d;
  hs_state_e         state_q, state_d;
  logic              key_valid_q, key_valid_d;
  key_code_t         key_code_q, key_code_d;
  logic              overrun_q, overrun_d;
  logic              ev_s;
  key_code_t         ev_idx_s;

  // Columns idle high; reset the synchroniser to the released level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_meta_q <= 4'hF;
      col_sync_q <= 4'hF;
    end else begin
      col_meta_q <= col_n;
      col_sync_q <= col_meta_q;
    end
  end

  always_comb begin
    scan_cnt_d   = scan_cnt_q + SCAN_ONE;
    row_idx_d    = row_idx_q;
    frame_d      = frame_q;
    frame_done_d = 1'b0;
    if (scan_cnt_q == SCAN_LAST) begin
      scan_cnt_d                    = '0;
      row_idx_d                     = row_idx_q + 2'd1;
      frame_d[{row_idx_q, 2'b00} +: 4] = ~col_sync_q;
      frame_done_d                  = (row_idx_q == 2'd3);
    end else begin
      frame_done_d = 1'b0;
    end
    row_n_d = ROW_SEL[row_idx_d];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q   <= '0;
      row_idx_q    <= 2'd0;
      row_n_q      <= 4'b1110;
      frame_q      <= 16'h0000;
      frame_done_q <= 1'b0;
    end else begin
      scan_cnt_q   <= scan_cnt_d;
      row_idx_q    <= row_idx_d;
      row_n_q      <= row_n_d;
      frame_q      <= frame_d;
      frame_done_q <= frame_done_d;
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst_n      (rst_n),
    .eval_i     (frame_done_q),
    .frame_i    (frame_q),
    .keys_o     (keys),
    .any_key_o  (any_key),
    .event_o    (ev_s),
    .event_idx_o(ev_idx_s)
  );

  always_comb begin
    state_d     = state_q;
    key_valid_d = key_valid_q;
    key_code_d  = key_code_q;
    overrun_d   = overrun_q;
    case (state_q)
      IDLE: begin
        if (ev_s) begin
          state_d     = PENDING;
          key_valid_d = 1'b1;
          key_code_d  = ev_idx_s;
        end else begin
          state_d = IDLE;
        end
      end
      PENDING: begin
        // Ack and a new event together hand over straight to the new key.
        if (ev_s && key_ack) begin
          key_code_d = ev_idx_s;
        end else if (ev_s) begin
          overrun_d = 1'b1;
        end else if (key_ack) begin
          state_d     = IDLE;
          key_valid_d = 1'b0;
          overrun_d   = 1'b0;
        end else begin
          state_d = PENDING;
        end
      end
      default: begin
        state_d     = IDLE;
        key_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      key_valid_q <= 1'b0;
      key_code_q  <= 4'd0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
      overrun_q   <= overrun_d;
    end
  end

  assign row_n     = row_n_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;
  assign overrun   = overrun_q;

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scanned 4x4 matrix keypad reader, the input-side counterpart of the 7-segment scan driver.
- Drives one active-low row at a time with the same one-hot pattern as digit select (1110, 1101, 1011, 0111).
- Samples active-low columns and debounces whole frames.
- Reports new key presses over a valid/ack handshake to the CPU/IO bus.

Parameters:
SCAN_DIV, 1000, clock cycles each row is held low; minimum 4
DEBOUNCE_FRAMES, 4, consecutive identical frames required before the stable key map updates; minimum 1

Ports:
clk  input  1  system clock
rst_n  input  1  reset; one clock; reset is asynchronous and active-low
col_n  input  4  column lines, active-low (pull-ups), asynchronous to clk
key_ack  input  1  consumer acknowledges the held key_code
row_n  output  4  row drive, active-low one-hot
keys  output  16  debounced key map, bit = row*4+col, 1 = pressed
any_key  output  1  OR of keys
key_valid  output  1  a new press is pending
key_code  output  4  index of the pending key
overrun  output  1  sticky: a press was lost while key_valid was high

Behaviour:
- Reset values:
  - row_n=4'b1110, keys=0, any_key=0, key_valid=0, key_code=0, overrun=0.
  - scan_cnt=0, row_idx=0, frame/prev_frame=0, match_cnt=0.
- Synchroniser: col_n passes through a 2-flop synchroniser before use.
- Scan:
  - scan_cnt runs 0..SCAN_DIV-1.
  - At scan_cnt==SCAN_DIV-1, frame[row_idx*4+c] is set to ~col_sync[c] for c=0..3.
  - On the same edge row_idx increments; 3 wraps to 0.
  - row_n is the registered one-hot of row_idx.
- Frame end: the cycle row 3 is sampled; the completed 16-bit frame is evaluated on the following cycle.
- Debounce, evaluated once per frame end:
  - frame==prev_frame: match_cnt increments, saturating at DEBOUNCE_FRAMES. Otherwise match_cnt=1.
  - prev_frame is updated to frame.
  - When match_cnt transitions to DEBOUNCE_FRAMES: keys<=frame, then the event check runs on the next cycle.
  - Further identical frames do not reload keys.
- Event check:
  - newly = keys_new & ~keys_old.
  - If newly is nonzero, the lowest set index is the event key.
  - Other simultaneously new keys appear in keys only; no event is generated for them.
  - Releases produce no events.
- Handshake FSM, states IDLE and PENDING:
  - IDLE + event: key_code<=index, key_valid<=1, go to PENDING.
  - PENDING + key_ack: key_valid<=0, go to IDLE.
  - PENDING + event without ack: key_code is kept (oldest wins), overrun<=1.
  - PENDING + event and ack in the same cycle: the new event is loaded, key_valid stays 1, overrun is unchanged.
  - overrun clears only on key_ack when no overrun event occurs in that cycle.
  - key_ack in IDLE is ignored.
- Latency: a press stable from frame k updates keys at evaluation of frame k+DEBOUNCE_FRAMES-1. key_valid rises 2 cycles after that frame end.
- Reset mid-scan: all state returns to reset values immediately; the partial frame is discarded.

Optional Feature:
KEYPAD_GHOST_REJECT_EN
- Defined: any frame with more than 2 bits set is discarded at evaluation. prev_frame, match_cnt and keys are unchanged, so phantom keys from 3-key rectangles are never reported.
- Undefined: every frame is evaluated as above.

Decomposition:
- Package keypad_pkg:
  - row one-hot constants ROW_SEL[0..3] = 1110/1101/1011/0111.
  - 4-bit key_code_t, 16-bit key_map_t.
  - FSM state enum {IDLE, PENDING}.
- Sub-module keypad_debounce: frame compare, match counter, keys register, newly-pressed priority encoder.
- The top holds the synchroniser, scan counter and handshake FSM.

Test Plan:
1. Reset, then idle with col_n=4'hF (SCAN_DIV=4, DEBOUNCE_FRAMES=3). row_n cycles 1110→1101→1011→0111 every 4 cycles; keys=0; key_valid stays 0.
2. Hold key 6 (col 2 low while row 1 driven) for 5 frames. keys=16'h0040 after frame 3; key_valid=1 with key_code=6; ack → key_valid=0; no second event while held.
3. Bounce key 6 on alternate frames for 6 frames, then hold. No update until 3 identical frames; exactly one event with key_code=6.
4. Press keys 3 and 9 together and hold. keys=16'h0208; key_code=3; no event for 9.
5. Press key 1, do not ack, then add key 12. key_code stays 1; overrun=1; ack clears key_valid and overrun.
6. Assert rst_n=0 mid-row-2 while key 5 is pending. All outputs return to reset values immediately; after release, key 5 is re-reported after 3 frames.
7. (KEYPAD_GHOST_REJECT_EN) Hold keys 0, 1 and 4. keys remains 0; no event.
